// File: rtl/pl_bram_rd_engine_if.sv
// BRAM read port plus AXI4-Stream output of the BRAM read engine.
// The master side is the engine; the slave side is the BRAM and stream sink.
interface pl_bram_rd_engine_if #(
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH = 32
);
  logic                         bram_en;
  logic [BRAM_DATA_WIDTH/8-1:0] bram_we;
  logic [BRAM_ADDR_WIDTH-1:0]   bram_addr;
  logic [BRAM_DATA_WIDTH-1:0]   bram_rddata;
  logic [BRAM_DATA_WIDTH-1:0]   m_axis_tdata;
  logic                         m_axis_tvalid;
  logic                         m_axis_tready;
  logic                         m_axis_tlast;

  modport master (
    output bram_en, output bram_we, output bram_addr, input bram_rddata,
    output m_axis_tdata, output m_axis_tvalid, output m_axis_tlast,
    input m_axis_tready
  );

  modport slave (
    input bram_en, input bram_we, input bram_addr, output bram_rddata,
    input m_axis_tdata, input m_axis_tvalid, input m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/pl_bram_rd_engine.sv
// Sequential BRAM reader: streams xfer_len words starting at start_addr out
// of an AXI4-Stream master, throttled by a credit count so the output FIFO
// can never overflow.
module pl_bram_rd_engine #(
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int RD_LATENCY      = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       s00_axi_aclk,
  input  logic                       s00_axi_aresetn,
  input  logic                       start,
  input  logic [BRAM_ADDR_WIDTH-1:0] start_addr,
  input  logic [31:0]                xfer_len,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                words_sent,
  pl_bram_rd_engine_if.master        bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_STEP = BRAM_ADDR_WIDTH'(BRAM_DATA_WIDTH / 8);

  if (RD_LATENCY < 1 || RD_LATENCY > 2 || FIFO_DEPTH < RD_LATENCY + 2 ||
      (1 << PW) != FIFO_DEPTH) begin : g_bad_param
    $error("pl_bram_rd_engine: illegal RD_LATENCY / FIFO_DEPTH");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                     state;
  logic                       en_q;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]                issue_left;
  logic [31:0]                issue_left_n;
  logic [31:0]                len_q;
  logic [CW-1:0]              credit;
  logic [CW-1:0]              credit_n;
  logic [RD_LATENCY-1:0]      vld_p;
  logic [PW:0]                wr_ptr;
  logic [PW:0]                rd_ptr;
  logic [CW-1:0]              occ;
  logic                       fifo_wr;
  logic                       fifo_rd;
  logic                       last_beat;
  logic                       addr_lsb_unused;
  logic [BRAM_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  // Byte-lane bits of the start address are dropped: reads are word aligned.
  assign addr_lsb_unused = ^start_addr[1:0];

  assign fifo_wr      = vld_p[RD_LATENCY-1];
  assign fifo_rd      = bus.m_axis_tvalid && bus.m_axis_tready;
  assign occ          = wr_ptr - rd_ptr;
  // credit = FIFO occupancy + reads in flight; a read costs one credit when
  // issued and returns it when its word leaves the FIFO.
  assign credit_n     = credit + CW'(en_q) - CW'(fifo_rd);
  assign issue_left_n = issue_left - 32'(en_q);
  assign last_beat    = (words_sent == len_q - 32'd1);

  assign bus.bram_en       = en_q;
  assign bus.bram_addr     = addr_q;
  assign bus.bram_we       = '0;
  assign bus.m_axis_tvalid = (wr_ptr != rd_ptr);
  assign bus.m_axis_tdata  = bus.m_axis_tvalid ? fifo_mem[rd_ptr[PW-1:0]] : '0;
  assign bus.m_axis_tlast  = bus.m_axis_tvalid && last_beat;

  // Transfer control: start acceptance, read issue, completion status.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_sent <= '0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      issue_left <= '0;
      len_q      <= '0;
    end else begin
      if (fifo_rd) words_sent <= words_sent + 32'd1;
      case (state)
        IDLE: begin
          if (start) begin
            words_sent <= '0;
            if (xfer_len != 32'd0) begin
              len_q      <= xfer_len;
              issue_left <= xfer_len;
              addr_q     <= {start_addr[BRAM_ADDR_WIDTH-1:2], 2'b00};
              en_q       <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
              state      <= ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (en_q) begin
            addr_q     <= addr_q + ADDR_STEP;
            issue_left <= issue_left_n;
          end
          en_q <= (issue_left_n != 32'd0) && (credit_n < DEPTH_C);
          if (issue_left_n == 32'd0) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_rd && last_beat) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Credit counter tracking FIFO occupancy plus outstanding reads.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) credit <= '0;
    else                  credit <= credit_n;
  end

  // Read-valid pipeline matching the BRAM latency; cleared on reset so
  // in-flight data is discarded.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) vld_p <= '0;
    else                  vld_p <= RD_LATENCY'({vld_p, en_q});
  end

  // FIFO pointers; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage, written with the BRAM word as its valid bit emerges.
  always_ff @(posedge s00_axi_aclk) begin
    if (fifo_wr) fifo_mem[wr_ptr[PW-1:0]] <= bus.bram_rddata;
  end

  // The credit scheme must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge s00_axi_aclk) disable iff (!s00_axi_aresetn)
    !(fifo_wr && (occ == DEPTH_C)));
endmodule

// File: tb/tb_pl_bram_rd_engine.sv
// Bench for pl_bram_rd_engine: a 32-bit-address and a 12-bit-address
// instance run in lock-step against a transfer-level reference model.
module tb_pl_bram_rd_engine;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] start_addr;
  logic [31:0] xfer_len;
  logic [11:0] start_addr12;
  logic        tready;
  logic        busy32, done32, busy12, done12;
  logic [31:0] ws32, ws12;
  int          tready_mode;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  pl_bram_rd_engine_if #(.BRAM_ADDR_WIDTH(32), .BRAM_DATA_WIDTH(32)) bus32 ();
  pl_bram_rd_engine_if #(.BRAM_ADDR_WIDTH(12), .BRAM_DATA_WIDTH(32)) bus12 ();

  assign start_addr12        = start_addr[11:0];
  assign bus32.m_axis_tready = tready;
  assign bus12.m_axis_tready = tready;

  pl_bram_rd_engine #(.BRAM_ADDR_WIDTH(32), .BRAM_DATA_WIDTH(32), .RD_LATENCY(1), .FIFO_DEPTH(DEPTH)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .start(start), .start_addr(start_addr),
    .xfer_len(xfer_len), .busy(busy32), .done(done32), .words_sent(ws32), .bus(bus32));

  pl_bram_rd_engine #(.BRAM_ADDR_WIDTH(12), .BRAM_DATA_WIDTH(32), .RD_LATENCY(1), .FIFO_DEPTH(DEPTH)) dut12 (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .start(start), .start_addr(start_addr12),
    .xfer_len(xfer_len), .busy(busy12), .done(done12), .words_sent(ws12), .bus(bus12));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM contents: the word at byte address a holds a/4 + 1; latency 1.
  always @(posedge clk) begin
    if (bus32.bram_en) bus32.bram_rddata <= (bus32.bram_addr >> 2) + 32'd1;
    if (bus12.bram_en) bus12.bram_rddata <= 32'(bus12.bram_addr >> 2) + 32'd1;
  end

  function automatic logic [31:0] amask(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_0FFF;
  endfunction

  function automatic logic [31:0] word_at(input int d, input logic [31:0] a);
    return ((a & amask(d)) >> 2) + 32'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state per instance (0: 32-bit address, 1: 12-bit address)
  logic        m_busy [2];
  logic        m_done [2];
  logic [31:0] m_sent [2], m_len [2], m_base [2], issued [2], accepted [2];
  logic        o_busy [2], o_done [2], o_en [2], o_tvalid [2], o_tlast [2], o_we [2];
  logic [31:0] o_ws [2], o_addr [2], o_tdata [2];

  // Captured traffic for the literal expectations
  logic [31:0] cap_a0 [$], cap_d0 [$], cap_l0 [$], cap_a1 [$], cap_d1 [$], cap_l1 [$];
  int          first_en_cyc, first_vld_cyc;

  // Compare every cycle, capture traffic, then advance the model over the next edge.
  always @(negedge clk) begin
    o_busy[0] = busy32;  o_done[0] = done32;  o_ws[0] = ws32;
    o_en[0] = bus32.bram_en;  o_addr[0] = bus32.bram_addr;  o_we[0] = |bus32.bram_we;
    o_tvalid[0] = bus32.m_axis_tvalid;  o_tdata[0] = bus32.m_axis_tdata;  o_tlast[0] = bus32.m_axis_tlast;
    o_busy[1] = busy12;  o_done[1] = done12;  o_ws[1] = ws12;
    o_en[1] = bus12.bram_en;  o_addr[1] = {20'b0, bus12.bram_addr};  o_we[1] = |bus12.bram_we;
    o_tvalid[1] = bus12.m_axis_tvalid;  o_tdata[1] = bus12.m_axis_tdata;  o_tlast[1] = bus12.m_axis_tlast;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk($sformatf("d%0d_rst_flags", d),
            32'({o_busy[d], o_done[d], o_en[d], o_tvalid[d], o_tlast[d], o_we[d]}), 32'd0);
        chk($sformatf("d%0d_rst_ws", d), o_ws[d], 32'd0);
        chk($sformatf("d%0d_rst_addr", d), o_addr[d], 32'd0);
        chk($sformatf("d%0d_rst_tdata", d), o_tdata[d], 32'd0);
        m_busy[d] = 1'b0; m_done[d] = 1'b0; m_sent[d] = '0; m_len[d] = '0;
        m_base[d] = '0; issued[d] = '0; accepted[d] = '0;
      end else begin
        chk($sformatf("d%0d_busy", d), 32'(o_busy[d]), 32'(m_busy[d]));
        chk($sformatf("d%0d_done", d), 32'(o_done[d]), 32'(m_done[d]));
        chk($sformatf("d%0d_words_sent", d), o_ws[d], m_sent[d]);
        chk($sformatf("d%0d_we", d), 32'(o_we[d]), 32'd0);
        if (o_en[d]) begin
          chk($sformatf("d%0d_en_in_xfer", d), 32'(m_busy[d] && (issued[d] < m_len[d])), 32'd1);
          chk($sformatf("d%0d_bram_addr", d), o_addr[d], (m_base[d] + 32'd4 * issued[d]) & amask(d));
          chk($sformatf("d%0d_credit", d), 32'((issued[d] - accepted[d]) < DEPTH), 32'd1);
        end
        if (o_tvalid[d]) begin
          chk($sformatf("d%0d_tvalid_pending", d), 32'(m_busy[d] && (m_sent[d] < issued[d])), 32'd1);
          chk($sformatf("d%0d_tdata", d), o_tdata[d], word_at(d, m_base[d] + 32'd4 * m_sent[d]));
          chk($sformatf("d%0d_tlast", d), 32'(o_tlast[d]), 32'(m_sent[d] == m_len[d] - 32'd1));
        end
        if (d == 0) begin
          if (o_en[0]) cap_a0.push_back(o_addr[0]);
          if (o_en[0] && first_en_cyc < 0) first_en_cyc = cyc;
          if (o_tvalid[0] && first_vld_cyc < 0) first_vld_cyc = cyc;
          if (o_tvalid[0] && tready) begin cap_d0.push_back(o_tdata[0]); cap_l0.push_back(32'(o_tlast[0])); end
        end else begin
          if (o_en[1]) cap_a1.push_back(o_addr[1]);
          if (o_tvalid[1] && tready) begin cap_d1.push_back(o_tdata[1]); cap_l1.push_back(32'(o_tlast[1])); end
        end
        if (start && !m_busy[d]) begin
          m_sent[d] = '0;
          if (xfer_len != 32'd0) begin
            m_busy[d] = 1'b1; m_done[d] = 1'b0; m_len[d] = xfer_len;
            m_base[d] = {start_addr[31:2], 2'b00} & amask(d);
            issued[d] = '0; accepted[d] = '0;
          end else begin
            m_done[d] = 1'b1;
          end
        end else begin
          if (o_en[d]) issued[d] = issued[d] + 32'd1;
          if (o_tvalid[d] && tready) begin
            m_sent[d] = m_sent[d] + 32'd1;
            accepted[d] = accepted[d] + 32'd1;
            if (m_sent[d] == m_len[d]) begin
              chk($sformatf("d%0d_issued_all", d), issued[d], m_len[d]);
              m_busy[d] = 1'b0;
              m_done[d] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Stream sink: 0 always ready, 1 random, 2 toggling, 3 stalled.
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tready_mode)
        0:       tready = 1'b1;
        1:       tready = ($urandom_range(0, 2) != 0);
        2:       tready = ~tready;
        default: tready = 1'b0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_caps();
    cap_a0.delete(); cap_d0.delete(); cap_l0.delete();
    cap_a1.delete(); cap_d1.delete(); cap_l1.delete();
    first_en_cyc = -1; first_vld_cyc = -1;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] l);
    start = 1'b1; start_addr = a; xfer_len = l;
    step();
    start = 1'b0;
  endtask

  // Wait for both instances to go idle, optionally firing starts while busy.
  task automatic wait_idle(input int budget, input bit noise);
    int n = 0;
    while ((busy32 || busy12) && n < budget) begin
      if (noise && $urandom_range(0, 15) == 0) begin
        start = 1'b1; start_addr = $urandom; xfer_len = 32'($urandom_range(0, 30));
      end
      step();
      start = 1'b0;
      n++;
    end
    chk("idle_timeout", 32'(busy32 | busy12), 32'd0);
    step(); step();
  endtask

  logic [31:0] lit_a [4];
  logic [31:0] lit_d [4];
  logic [31:0] lenr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst_n = 1'b1; start = 1'b0; start_addr = '0; xfer_len = '0; tready_mode = 0;
    clear_caps();
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("reset_busy", 32'(busy32), 32'd0);
    chk("reset_done", 32'(done32), 32'd0);
    chk("reset_tvalid", 32'(bus32.m_axis_tvalid), 32'd0);

    // Four words from address 0, sink always ready
    clear_caps();
    pulse_start(32'h0, 32'd4);
    wait_idle(100, 1'b0);
    lit_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    lit_d = '{32'd1, 32'd2, 32'd3, 32'd4};
    chk("t1_issues", 32'(cap_a0.size()), 32'd4);
    chk("t1_beats", 32'(cap_d0.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), cap_a0[i], lit_a[i]);
      chk($sformatf("t1_data%0d", i), cap_d0[i], lit_d[i]);
      chk($sformatf("t1_last%0d", i), cap_l0[i], (i == 3) ? 32'd1 : 32'd0);
    end
    chk("t1_latency", 32'(first_vld_cyc - first_en_cyc), 32'd2);
    chk("t1_done", 32'(done32), 32'd1);
    chk("t1_busy", 32'(busy32), 32'd0);
    chk("t1_words_sent", ws32, 32'd4);

    // Sixteen words with a toggling sink and a 10-cycle stall
    clear_caps();
    pulse_start(32'h100, 32'd16);
    tready_mode = 2;
    repeat (6) step();
    tready_mode = 3;
    repeat (10) step();
    tready_mode = 2;
    wait_idle(300, 1'b0);
    chk("t2_beats", 32'(cap_d0.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("t2_data%0d", i), cap_d0[i], 32'h41 + 32'(i));
    chk("t2_words_sent", ws32, 32'd16);

    // Zero-length transfer
    tready_mode = 0;
    clear_caps();
    pulse_start(32'h40, 32'd0);
    chk("t3_done_next", 32'(done32), 32'd1);
    chk("t3_busy", 32'(busy32), 32'd0);
    repeat (5) step();
    chk("t3_no_issue", 32'(cap_a0.size()), 32'd0);
    chk("t3_no_beat", 32'(first_vld_cyc < 0), 32'd1);

    // A start while busy is ignored
    clear_caps();
    tready_mode = 1;
    pulse_start(32'h200, 32'd10);
    repeat (3) step();
    start = 1'b1; start_addr = 32'h800; xfer_len = 32'd5;
    step();
    start = 1'b0;
    wait_idle(300, 1'b0);
    chk("t4_words_sent", ws32, 32'd10);
    chk("t4_beats", 32'(cap_d0.size()), 32'd10);
    chk("t4_first_addr", cap_a0[0], 32'h200);
    chk("t4_last_data", cap_d0[9], 32'h8A);

    // Reset after three of eight beats, then a clean two-word transfer
    tready_mode = 0;
    pulse_start(32'h0, 32'd8);
    begin
      int n = 0;
      while (ws32 != 32'd3 && n < 100) begin step(); n++; end
    end
    chk("t5_reach3", ws32, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t5_async_busy", 32'(busy32), 32'd0);
    chk("t5_async_ws", ws32, 32'd0);
    chk("t5_async_en", 32'(bus32.bram_en), 32'd0);
    chk("t5_async_tvalid", 32'(bus32.m_axis_tvalid), 32'd0);
    chk("t5_async_addr", bus32.bram_addr, 32'd0);
    chk("t5_async_ws12", ws12, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    clear_caps();
    pulse_start(32'h20, 32'd2);
    wait_idle(100, 1'b0);
    chk("t5_beats", 32'(cap_d0.size()), 32'd2);
    chk("t5_addr0", cap_a0[0], 32'h20);
    chk("t5_addr1", cap_a0[1], 32'h24);
    chk("t5_data0", cap_d0[0], 32'd9);
    chk("t5_data1", cap_d0[1], 32'd10);
    chk("t5_words_sent", ws32, 32'd2);

    // Address wrap on the 12-bit instance
    clear_caps();
    pulse_start(32'hFF8, 32'd4);
    wait_idle(100, 1'b0);
    lit_a = '{32'hFF8, 32'hFFC, 32'h000, 32'h004};
    lit_d = '{32'h3FF, 32'h400, 32'h001, 32'h002};
    chk("t6_beats12", 32'(cap_d1.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_addr12_%0d", i), cap_a1[i], lit_a[i]);
      chk($sformatf("t6_data12_%0d", i), cap_d1[i], lit_d[i]);
      chk($sformatf("t6_last12_%0d", i), cap_l1[i], (i == 3) ? 32'd1 : 32'd0);
    end
    chk("t6_addr32_2", cap_a0[2], 32'h1000);

    // Randomized transfers with random sink and stray starts
    for (int t = 0; t < 30; t++) begin
      tready_mode = $urandom_range(0, 1);
      lenr = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 24));
      pulse_start($urandom, lenr);
      wait_idle(600, 1'b1);
      chk($sformatf("rnd%0d_words_sent", t), ws32, lenr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
